// File: rtl/audio_level_meter_pkg.sv
// Shared widths, FSM encoding and the saturating magnitude helper for the
// audio level meter.
package audio_pkg;

  localparam int AUD_W = 16;
  localparam int LVL_W = 4;
  localparam int MAG_W = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  // |x| in MAG_W bits; the single unrepresentable input -32768 clips to 32767.
  function automatic logic [MAG_W-1:0] abs_sat(input logic signed [AUD_W-1:0] x);
    logic [AUD_W-1:0] ux;
    logic [AUD_W-1:0] neg;
    ux  = x;
    neg = ~ux + 16'd1;
    if (ux == 16'h8000) return {MAG_W{1'b1}};
    if (ux[AUD_W-1]) return neg[MAG_W-1:0];
    return ux[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/audio_level_meter_if.sv
// Sample-in / level-out bus between the I2S receive path and the meter;
// master drives samples and enable, slave (the meter) drives the levels.
interface audio_level_meter_if;

  logic                        meter_en;
  logic                        rx_done;
  logic [31:0]                 adc_data;
  logic [audio_pkg::LVL_W-1:0] lvl_l;
  logic [audio_pkg::LVL_W-1:0] lvl_r;
  logic [audio_pkg::LVL_W-1:0] peak_l;
  logic [audio_pkg::LVL_W-1:0] peak_r;
  logic                        lvl_valid;

  modport master (
    output meter_en, rx_done, adc_data,
    input  lvl_l, lvl_r, peak_l, peak_r, lvl_valid
  );

  modport slave (
    input  meter_en, rx_done, adc_data,
    output lvl_l, lvl_r, peak_l, peak_r, lvl_valid
  );

endinterface

// File: rtl/audio_level_meter_lvl_calc.sv
// Combinational level encoder: saturating magnitude followed by a
// leading-one search, giving 0 for silence and floor(log2(mag))+1 otherwise.
module audio_lvl_calc
  import audio_pkg::*;
(
  input  logic signed [AUD_W-1:0] x_i,
  output logic        [LVL_W-1:0] lvl_o
);

  logic [MAG_W-1:0] mag;

  always_comb begin
    mag   = abs_sat(x_i);
    lvl_o = '0;
    for (int i = 0; i < MAG_W; i++) begin
      if (mag[i]) lvl_o = LVL_W'(i + 1);
    end
  end

endmodule

// File: rtl/audio_level_meter.sv
// Stereo peak level meter: windowed peak magnitude per channel, mapped to a
// 0..15 bar level, with a peak-hold marker that decays after HOLD_WIN windows.
module audio_level_meter
  import audio_pkg::*;
#(
  parameter int WIN_SAMPLES = 256,
  parameter int HOLD_WIN    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  audio_level_meter_if.slave bus
);

  localparam int               CNT_W     = $clog2(WIN_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIN_SAMPLES - 1);
  localparam logic [7:0]       HOLD_INIT = 8'(HOLD_WIN);

  state_e state_q, state_d;

  logic [MAG_W-1:0] mag_l_p1_q, mag_l_p1_d, mag_r_p1_q, mag_r_p1_d;
  logic             vld_p1_q, vld_p1_d;
  logic [MAG_W-1:0] max_l_p2_q, max_l_p2_d, max_r_p2_q, max_r_p2_d;
  logic [MAG_W-1:0] win_l_p2_q, win_l_p2_d, win_r_p2_q, win_r_p2_d;
  logic [CNT_W-1:0] cnt_p2_q, cnt_p2_d;
  logic             done_p2_q, done_p2_d;
  logic [MAG_W-1:0] fold_l, fold_r;

  logic [LVL_W-1:0] lvl_l_q, lvl_l_d, lvl_r_q, lvl_r_d;
  logic [LVL_W-1:0] peak_l_q, peak_l_d, peak_r_q, peak_r_d;
  logic [7:0]       hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic             lvl_valid_q, lvl_valid_d;

  logic signed [AUD_W-1:0] samp_l, samp_r, win_l_s, win_r_s;
  logic        [LVL_W-1:0] calc_l, calc_r;

  assign samp_l  = bus.adc_data[31:16];
  assign samp_r  = bus.adc_data[15:0];
  assign win_l_s = {1'b0, win_l_p2_q};
  assign win_r_s = {1'b0, win_r_p2_q};

  audio_lvl_calc u_calc_l (.x_i(win_l_s), .lvl_o(calc_l));
  audio_lvl_calc u_calc_r (.x_i(win_r_s), .lvl_o(calc_r));

  // Returns {peak, hold} after one window; pk > lvl >= 0 guarantees pk-1 is safe.
  function automatic logic [LVL_W+7:0] peak_upd(input logic [LVL_W-1:0] lvl,
                                                input logic [LVL_W-1:0] pk,
                                                input logic [7:0]       hold);
    logic [LVL_W-1:0] dec;
    dec = pk - 1'b1;
    if (lvl >= pk) return {lvl, HOLD_INIT};
    if (hold != 8'd0) return {pk, hold - 8'd1};
    return {(dec > lvl) ? dec : lvl, 8'd0};
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_ACCUM;
      ST_ACCUM:  if (done_p2_q) state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_ACCUM;
      default:   state_d = ST_IDLE;
    endcase
    if (!bus.meter_en) state_d = ST_IDLE;
  end

  always_comb begin
    mag_l_p1_d  = mag_l_p1_q;
    mag_r_p1_d  = mag_r_p1_q;
    vld_p1_d    = bus.rx_done && (state_q != ST_IDLE);
    max_l_p2_d  = max_l_p2_q;
    max_r_p2_d  = max_r_p2_q;
    win_l_p2_d  = win_l_p2_q;
    win_r_p2_d  = win_r_p2_q;
    cnt_p2_d    = cnt_p2_q;
    done_p2_d   = 1'b0;
    fold_l      = (mag_l_p1_q > max_l_p2_q) ? mag_l_p1_q : max_l_p2_q;
    fold_r      = (mag_r_p1_q > max_r_p2_q) ? mag_r_p1_q : max_r_p2_q;
    lvl_l_d     = lvl_l_q;
    lvl_r_d     = lvl_r_q;
    peak_l_d    = peak_l_q;
    peak_r_d    = peak_r_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    lvl_valid_d = 1'b0;

    // stage 1: capture magnitudes of every accepted sample
    if (vld_p1_d) begin
      mag_l_p1_d = abs_sat(samp_l);
      mag_r_p1_d = abs_sat(samp_r);
    end

    // stage 2: fold into the running max; the closing sample hands the window
    // to a snapshot so the next window can start folding without a gap
    if (vld_p1_q) begin
      if (cnt_p2_q == CNT_LAST) begin
        win_l_p2_d = fold_l;
        win_r_p2_d = fold_r;
        max_l_p2_d = '0;
        max_r_p2_d = '0;
        cnt_p2_d   = '0;
        done_p2_d  = 1'b1;
      end else begin
        max_l_p2_d = fold_l;
        max_r_p2_d = fold_r;
        cnt_p2_d   = cnt_p2_q + 1'b1;
      end
    end

    // update: publish levels and advance peak-hold
    if (state_q == ST_UPDATE) begin
      lvl_l_d                = calc_l;
      lvl_r_d                = calc_r;
      {peak_l_d, hold_l_d}   = peak_upd(calc_l, peak_l_q, hold_l_q);
      {peak_r_d, hold_r_d}   = peak_upd(calc_r, peak_r_q, hold_r_q);
      lvl_valid_d            = 1'b1;
    end

    if (!bus.meter_en) begin
      mag_l_p1_d  = '0;
      mag_r_p1_d  = '0;
      vld_p1_d    = 1'b0;
      max_l_p2_d  = '0;
      max_r_p2_d  = '0;
      win_l_p2_d  = '0;
      win_r_p2_d  = '0;
      cnt_p2_d    = '0;
      done_p2_d   = 1'b0;
      lvl_l_d     = '0;
      lvl_r_d     = '0;
      peak_l_d    = '0;
      peak_r_d    = '0;
      hold_l_d    = '0;
      hold_r_d    = '0;
      lvl_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mag_l_p1_q  <= '0;
      mag_r_p1_q  <= '0;
      vld_p1_q    <= 1'b0;
      max_l_p2_q  <= '0;
      max_r_p2_q  <= '0;
      win_l_p2_q  <= '0;
      win_r_p2_q  <= '0;
      cnt_p2_q    <= '0;
      done_p2_q   <= 1'b0;
      lvl_l_q     <= '0;
      lvl_r_q     <= '0;
      peak_l_q    <= '0;
      peak_r_q    <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      lvl_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_l_p1_q  <= mag_l_p1_d;
      mag_r_p1_q  <= mag_r_p1_d;
      vld_p1_q    <= vld_p1_d;
      max_l_p2_q  <= max_l_p2_d;
      max_r_p2_q  <= max_r_p2_d;
      win_l_p2_q  <= win_l_p2_d;
      win_r_p2_q  <= win_r_p2_d;
      cnt_p2_q    <= cnt_p2_d;
      done_p2_q   <= done_p2_d;
      lvl_l_q     <= lvl_l_d;
      lvl_r_q     <= lvl_r_d;
      peak_l_q    <= peak_l_d;
      peak_r_q    <= peak_r_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      lvl_valid_q <= lvl_valid_d;
    end
  end

  assign bus.lvl_l     = lvl_l_q;
  assign bus.lvl_r     = lvl_r_q;
  assign bus.peak_l    = peak_l_q;
  assign bus.peak_r    = peak_r_q;
  assign bus.lvl_valid = lvl_valid_q;

endmodule

// File: tb/tb_audio_level_meter.sv
// Directed bench for audio_level_meter with 4-sample windows and a 2-window hold.
module tb_audio_level_meter;

  logic clk = 1'b0;
  logic rst_n;
  audio_level_meter_if bus();

  audio_level_meter #(.WIN_SAMPLES(4), .HOLD_WIN(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int pulses = 0;
  int rx_cyc = 0;
  logic [3:0] pl_l [64];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.lvl_valid) begin
      if (pulses < 64) pl_l[pulses] = bus.lvl_l;
      pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    bus.adc_data = {l, r};
    bus.rx_done  = 1'b1;
    tick();
    bus.rx_done  = 1'b0;
    rx_cyc       = cyc;
  endtask

  task automatic window(input logic [15:0] l, input logic [15:0] r);
    for (int i = 0; i < 4; i++) begin
      send(l, r);
      tick();
    end
  endtask

  task automatic wait_valid(output bit ok, output int vc);
    ok = 1'b0;
    vc = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.lvl_valid) begin
        ok = 1'b1;
        vc = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic restart();
    bus.meter_en = 1'b0;
    tick();
    bus.meter_en = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.meter_en = 1'b0;
    bus.rx_done  = 1'b0;
    bus.adc_data = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.lvl_l !== 4'd0) begin errors++; $display("FAIL reset_lvl_l: got %0d expected 0", bus.lvl_l); end
    checks++; if (bus.lvl_r !== 4'd0) begin errors++; $display("FAIL reset_lvl_r: got %0d expected 0", bus.lvl_r); end
    checks++; if (bus.peak_l !== 4'd0) begin errors++; $display("FAIL reset_peak_l: got %0d expected 0", bus.peak_l); end
    checks++; if (bus.peak_r !== 4'd0) begin errors++; $display("FAIL reset_peak_r: got %0d expected 0", bus.peak_r); end
    checks++; if (bus.lvl_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus.lvl_valid); end
    bus.meter_en = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    int vc;
    window(16'h0100, 16'hFF00);
    wait_valid(ok, vc);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: no lvl_valid within 20 cycles"); end
    checks++; if (vc - rx_cyc !== 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", vc - rx_cyc); end
    checks++; if (bus.lvl_l !== 4'd9) begin errors++; $display("FAIL basic_lvl_l: got %0d expected 9", bus.lvl_l); end
    checks++; if (bus.lvl_r !== 4'd9) begin errors++; $display("FAIL basic_lvl_r: got %0d expected 9", bus.lvl_r); end
    checks++; if (bus.peak_l !== 4'd9) begin errors++; $display("FAIL basic_peak_l: got %0d expected 9", bus.peak_l); end
    checks++; if (bus.peak_r !== 4'd9) begin errors++; $display("FAIL basic_peak_r: got %0d expected 9", bus.peak_r); end
    tick();
    checks++; if (bus.lvl_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %0b expected 0", bus.lvl_valid); end
  endtask

  task automatic test_saturation();
    bit ok;
    int vc;
    window(16'h8000, 16'h0000);
    wait_valid(ok, vc);
    checks++; if (!ok) begin errors++; $display("FAIL sat_timeout: no lvl_valid within 20 cycles"); end
    checks++; if (bus.lvl_l !== 4'd15) begin errors++; $display("FAIL sat_lvl_l: got %0d expected 15", bus.lvl_l); end
    checks++; if (bus.lvl_r !== 4'd0) begin errors++; $display("FAIL sat_lvl_r: got %0d expected 0", bus.lvl_r); end
    checks++; if (bus.peak_l !== 4'd15) begin errors++; $display("FAIL sat_peak_l: got %0d expected 15", bus.peak_l); end
    checks++; if (bus.peak_r !== 4'd9) begin errors++; $display("FAIL sat_peak_r_hold: got %0d expected 9", bus.peak_r); end
    tick();
    send(16'h0001, 16'h0000); tick();
    send(16'h7FFF, 16'h0000); tick();
    send(16'hFFFF, 16'h0000); tick();
    send(16'h0002, 16'h0000); tick();
    wait_valid(ok, vc);
    checks++; if (!ok) begin errors++; $display("FAIL mixed_timeout: no lvl_valid within 20 cycles"); end
    checks++; if (bus.lvl_l !== 4'd15) begin errors++; $display("FAIL mixed_lvl_l: got %0d expected 15", bus.lvl_l); end
    checks++; if (bus.lvl_r !== 4'd0) begin errors++; $display("FAIL mixed_lvl_r: got %0d expected 0", bus.lvl_r); end
    checks++; if (bus.peak_r !== 4'd9) begin errors++; $display("FAIL mixed_peak_r_hold: got %0d expected 9", bus.peak_r); end
    tick();
  endtask

  task automatic test_peak_decay();
    bit ok;
    int vc;
    int exp_pk [12] = '{12, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 3};
    restart();
    window(16'h0800, 16'h0004);
    wait_valid(ok, vc);
    checks++; if (!ok) begin errors++; $display("FAIL decay_start_timeout: no lvl_valid within 20 cycles"); end
    checks++; if (bus.lvl_l !== 4'd12) begin errors++; $display("FAIL decay_start_lvl_l: got %0d expected 12", bus.lvl_l); end
    checks++; if (bus.peak_l !== 4'd12) begin errors++; $display("FAIL decay_start_peak_l: got %0d expected 12", bus.peak_l); end
    tick();
    for (int w = 0; w < 12; w++) begin
      window(16'h0004, 16'h0004);
      wait_valid(ok, vc);
      checks++; if (!ok) begin errors++; $display("FAIL decay_timeout w%0d: no lvl_valid", w); end
      checks++; if (bus.lvl_l !== 4'd3) begin errors++; $display("FAIL decay_lvl_l w%0d: got %0d expected 3", w, bus.lvl_l); end
      checks++; if (int'(bus.peak_l) !== exp_pk[w]) begin errors++; $display("FAIL decay_peak_l w%0d: got %0d expected %0d", w, bus.peak_l, exp_pk[w]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq_l [8] = '{16'h0010, 16'h0010, 16'h0010, 16'h0400,
                               16'h0001, 16'h0001, 16'h0001, 16'h0002};
    int p0;
    restart();
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      bus.adc_data = {seq_l[i], 16'h0001};
      bus.rx_done  = 1'b1;
      tick();
    end
    bus.rx_done = 1'b0;
    repeat (8) tick();
    checks++; if (pulses - p0 !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", pulses - p0); end
    checks++; if (pl_l[p0] !== 4'd11) begin errors++; $display("FAIL b2b_win1_lvl_l: got %0d expected 11", pl_l[p0]); end
    checks++; if (pl_l[p0+1] !== 4'd2) begin errors++; $display("FAIL b2b_win2_lvl_l: got %0d expected 2", pl_l[p0+1]); end
  endtask

  task automatic test_meter_en_drop();
    bit ok;
    int vc;
    int p1;
    window(16'h0100, 16'h0100);
    wait_valid(ok, vc);
    checks++; if (bus.lvl_l !== 4'd9) begin errors++; $display("FAIL drop_pre_lvl_l: got %0d expected 9", bus.lvl_l); end
    tick();
    send(16'h0100, 16'h0100); tick();
    send(16'h0100, 16'h0100);
    bus.meter_en = 1'b0;
    tick();
    checks++; if (bus.lvl_l !== 4'd0) begin errors++; $display("FAIL drop_lvl_l: got %0d expected 0", bus.lvl_l); end
    checks++; if (bus.lvl_r !== 4'd0) begin errors++; $display("FAIL drop_lvl_r: got %0d expected 0", bus.lvl_r); end
    checks++; if (bus.peak_l !== 4'd0) begin errors++; $display("FAIL drop_peak_l: got %0d expected 0", bus.peak_l); end
    p1 = pulses;
    bus.meter_en = 1'b1;
    repeat (6) tick();
    checks++; if (pulses !== p1) begin errors++; $display("FAIL drop_no_pulse: got %0d pulses expected 0", pulses - p1); end
    window(16'h0020, 16'h0020);
    wait_valid(ok, vc);
    checks++; if (!ok) begin errors++; $display("FAIL drop_timeout: no lvl_valid within 20 cycles"); end
    checks++; if (vc - rx_cyc !== 3) begin errors++; $display("FAIL drop_latency: got %0d expected 3", vc - rx_cyc); end
    checks++; if (bus.lvl_l !== 4'd6) begin errors++; $display("FAIL drop_fresh_lvl_l: got %0d expected 6", bus.lvl_l); end
    tick();
    checks++; if (pulses - p1 !== 1) begin errors++; $display("FAIL drop_pulse_count: got %0d expected 1", pulses - p1); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int vc;
    window(16'h1000, 16'h1000);
    wait_valid(ok, vc);
    checks++; if (bus.lvl_l !== 4'd13) begin errors++; $display("FAIL rmid_pre_lvl_l: got %0d expected 13", bus.lvl_l); end
    tick();
    send(16'h7000, 16'h7000); tick();
    send(16'h7000, 16'h7000);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.lvl_l !== 4'd0) begin errors++; $display("FAIL rmid_lvl_l: got %0d expected 0", bus.lvl_l); end
    checks++; if (bus.lvl_r !== 4'd0) begin errors++; $display("FAIL rmid_lvl_r: got %0d expected 0", bus.lvl_r); end
    checks++; if (bus.peak_l !== 4'd0) begin errors++; $display("FAIL rmid_peak_l: got %0d expected 0", bus.peak_l); end
    checks++; if (bus.peak_r !== 4'd0) begin errors++; $display("FAIL rmid_peak_r: got %0d expected 0", bus.peak_r); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    window(16'h0002, 16'hFFFE);
    wait_valid(ok, vc);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout: no lvl_valid within 20 cycles"); end
    checks++; if (bus.lvl_l !== 4'd2) begin errors++; $display("FAIL rmid_fresh_lvl_l: got %0d expected 2", bus.lvl_l); end
    checks++; if (bus.lvl_r !== 4'd2) begin errors++; $display("FAIL rmid_fresh_lvl_r: got %0d expected 2", bus.lvl_r); end
    checks++; if (bus.peak_l !== 4'd2) begin errors++; $display("FAIL rmid_fresh_peak_l: got %0d expected 2", bus.peak_l); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_peak_decay();
    test_back_to_back();
    test_meter_en_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
